rs_issue_sched: RTL and testbench
=================================

# rs_issue_sched

Issue scheduler for the 16-entry reservation station. Each cycle it selects at most one ready entry per functional unit (FU0 ALU, FU1 ALU, FU2 mem), using a per-FU round-robin pointer for fairness. It holds each grant under a valid/ready handshake until that FU accepts it, and tells the RS table which entries to invalidate. It sits between the RS table (entry status in, clear vector out) and the issue registers feeding the FUs.

## Interface
Parameters:
- RS_DEPTH, 16, number of RS entries; power of two; index width IDX_W = log2(RS_DEPTH) = 4
- NUM_FU, 3, number of functional units; FU id 0..NUM_FU-1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous squash of in-flight grants
- ent_valid  in  16  RS entry valid bits
- ent_rdy  in  16  per-entry operand readiness (src1rdy & src2rdy)
- ent_fu  in  32  2-bit FU id per entry; entry i uses bits [2i+1:2i]
- fu_rdy  in  3  FU j can accept an issue this cycle
- grant_valid  out  3  registered; grant for FU j is held
- grant_idx  out  12  registered; 4-bit RS index per FU; FU j uses bits [4j+3:4j]
- clear_vec  out  16  combinational; one-hot OR of accepted grants; RS invalidates these entries at the same edge
- issue_cnt  out  32  registered count of accepted grants

## Operation
- accept[j] = grant_valid[j] & fu_rdy[j].
- Slot j is free when !grant_valid[j] or accept[j].
- held_mask: one-hot OR of grant_idx[j] over every j with grant_valid[j] = 1. This includes grants being accepted this cycle.
- cand[j][i] = ent_valid[i] & ent_rdy[i] & !held_mask[i] & (ent_fu[i] == j).
- An entry with ent_fu = 3 is never a candidate.
- Selection for FU j: the first i with cand[j][i], scanning ptr[j], ptr[j]+1, ... mod 16.
- Free slot with a candidate found at index k:
  - grant_valid[j] <= 1, grant_idx[j] <= k, ptr[j] <= k+1 mod 16.
- Free slot with no candidate: grant_valid[j] <= 0; grant_idx[j] and ptr[j] unchanged.
- Slot not free (valid and FU not ready): grant held unchanged; ptr[j] unchanged.
- FUs are disjoint by ent_fu, so one entry can never be granted to two FUs.
- clear_vec[i] = 1 iff some j has accept[j] and grant_idx[j] == i. It is forced to 0 while flush or reset is high.
- issue_cnt <= issue_cnt + popcount(accept), modulo 2^32. It does not increment during flush or reset.
- The grant payload is captured by the issue stage on accept. The scheduler never reads entry contents.

## Timing
- Reset values: grant_valid = 0, grant_idx = 0, issue_cnt = 0, all ptr = 0. clear_vec = 0 while reset is high.
- Latency: an entry that becomes ready in cycle t shows grant_valid in cycle t+1 at the earliest. The earliest accept/clear is in cycle t+1.
- Back-to-back throughput: with fu_rdy[j] held high, a new grant can load for FU j every cycle.
- Grant stability: once grant_valid[j] = 1, grant_idx[j] does not change until accept[j] or flush.
- Entry dropped while held (ent_valid[i] falls while grant i is held, e.g. an RS-side squash): the scheduler does not check this; upstream must use flush.
- flush (no reset): at the edge, grant_valid <= 0 and all ptr <= 0; issue_cnt is held; no new grant loads that cycle.
- reset together with flush: reset wins.
- Reset mid-handshake: the grant is dropped, it is not counted, and no clear is generated.
- Pointer wrap: a grant at index 15 sets ptr to 0.

## Test plan
- Reset: entries 3 (fu0) and 5 (fu2) valid and ready, reset high for 2 cycles. While reset is high: grant_valid = 0 and clear_vec = 0. After release: grant_valid = 3'b101, grant_idx fields FU0 = 3 and FU2 = 5, with fu_rdy = 3'b111; on that cycle clear_vec = 16'h0028 and issue_cnt = 2 next cycle.
- Round-robin: entries 1, 4 and 9 all fu0 and ready, fu_rdy[0] = 1, RS clears per clear_vec. Grants are 1, 4, 9 in consecutive cycles, then grant_valid[0] = 0. ptr wraps correctly when an entry at index 15 is granted.
- Mem backpressure: entry 7 (fu2) ready, fu_rdy[2] = 0 for 4 cycles. grant_valid[2] = 1 and grant_idx FU2 = 7 stay stable with clear_vec = 0. When fu_rdy[2] rises: clear_vec = 16'h0080, issue_cnt increments by 1. Meanwhile a second fu2 entry, 10, is granted only after entry 7 is accepted.
- Triple issue: entries 0 (fu0), 2 (fu1) and 14 (fu2) ready, all fu_rdy high. All three grants in one cycle; clear_vec = 16'h4005; issue_cnt += 3.
- Flush: grants held (fu_rdy = 0), flush pulsed. Next cycle grant_valid = 0, issue_cnt unchanged, clear_vec = 0 during flush; ptr restarts at 0.
- Illegal FU id: entry 6 with ent_fu = 3, valid and ready for 10 cycles -> never granted.

Source files
------------

// File: rtl/rs_issue_sched_if.sv
// Bundle between the RS table, the issue scheduler and the FU issue registers.
// master = scheduler side; slave = RS table / issue stage side.
interface rs_issue_sched_if #(
  parameter int RS_DEPTH = 16,
  parameter int NUM_FU   = 3
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0]         ent_valid;
  logic [RS_DEPTH-1:0]         ent_rdy;
  logic [2*RS_DEPTH-1:0]       ent_fu;
  logic [NUM_FU-1:0]           fu_rdy;
  logic [NUM_FU-1:0]           grant_valid;
  logic [NUM_FU*IDX_W-1:0]     grant_idx;
  logic [RS_DEPTH-1:0]         clear_vec;
  logic [31:0]                 issue_cnt;

  modport master (
    input  ent_valid, ent_rdy, ent_fu, fu_rdy,
    output grant_valid, grant_idx, clear_vec, issue_cnt
  );

  modport slave (
    output ent_valid, ent_rdy, ent_fu, fu_rdy,
    input  grant_valid, grant_idx, clear_vec, issue_cnt
  );
endinterface

// File: rtl/rs_issue_sched.sv
// Per-FU round-robin issue scheduler for the reservation station.
// Grants are held under valid/ready until the FU accepts them.
module rs_issue_sched #(
  parameter int RS_DEPTH = 16,
  parameter int NUM_FU   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  rs_issue_sched_if.master   bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int FU_W  = 2;

  logic [NUM_FU-1:0]             gv_q;
  logic [NUM_FU-1:0][IDX_W-1:0]  gidx_q;
  logic [NUM_FU-1:0][IDX_W-1:0]  ptr_q;
  logic [31:0]                   cnt_q;

  logic [NUM_FU-1:0]             accept;
  logic [NUM_FU-1:0]             slot_free;
  logic [NUM_FU-1:0]             found;
  logic [NUM_FU-1:0][IDX_W-1:0]  pick;
  logic [RS_DEPTH-1:0]           held_mask;
  logic [RS_DEPTH-1:0]           acc_mask;
  logic [31:0]                   acc_cnt;
  logic [IDX_W-1:0]              scan_idx;

  assign accept    = gv_q & bus.fu_rdy;
  assign slot_free = ~gv_q | accept;

  // Held mask includes grants being accepted now, so a just-issued entry
  // cannot be re-granted while the RS is invalidating it.
  always_comb begin
    held_mask = '0;
    acc_mask  = '0;
    acc_cnt   = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (gv_q[j]) held_mask[gidx_q[j]] = 1'b1;
      if (accept[j]) begin
        acc_mask[gidx_q[j]] = 1'b1;
        acc_cnt = acc_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    found    = '0;
    pick     = '0;
    scan_idx = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      for (int off = 0; off < RS_DEPTH; off++) begin
        scan_idx = ptr_q[j] + IDX_W'(off);
        if (!found[j] && bus.ent_valid[scan_idx] && bus.ent_rdy[scan_idx] &&
            !held_mask[scan_idx] &&
            (bus.ent_fu[FU_W*scan_idx +: FU_W] == FU_W'(j))) begin
          found[j] = 1'b1;
          pick[j]  = scan_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gv_q   <= '0;
      gidx_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      gv_q  <= '0;
      ptr_q <= '0;
    end else begin
      cnt_q <= cnt_q + acc_cnt;
      for (int j = 0; j < NUM_FU; j++) begin
        if (slot_free[j]) begin
          if (found[j]) begin
            gv_q[j]   <= 1'b1;
            gidx_q[j] <= pick[j];
            ptr_q[j]  <= pick[j] + IDX_W'(1);
          end else begin
            gv_q[j] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.grant_valid = gv_q;
  assign bus.grant_idx   = gidx_q;
  assign bus.clear_vec   = (reset || flush) ? '0 : acc_mask;
  assign bus.issue_cnt   = cnt_q;
endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed cycle table followed by randomized
// traffic checked against a behavioural scheduler model.
module tb_rs_issue_sched;
  logic clk;
  logic reset;
  logic flush;

  rs_issue_sched_if #(.RS_DEPTH(16), .NUM_FU(3)) sif ();

  rs_issue_sched #(.RS_DEPTH(16), .NUM_FU(3)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [15:0] val;
    logic [31:0] fu;
    logic [2:0]  frdy;
    logic [2:0]  e_gv;
    logic [11:0] e_gidx;
    logic [15:0] e_clr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add_vec(input logic rst, input logic fl, input logic [15:0] val,
                         input logic [31:0] fu, input logic [2:0] frdy,
                         input logic [2:0] gv, input logic [11:0] gidx,
                         input logic [15:0] clr, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.val = val; v.fu = fu; v.frdy = frdy;
    v.e_gv = gv; v.e_gidx = gidx; v.e_clr = clr; v.e_cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  int          m_gv[3];
  int          m_gidx[3];
  int          m_ptr[3];
  logic [31:0] m_cnt;
  bit          rs_val[16];
  int          rs_fu[16];
  bit          rs_rdy[16];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    sif.ent_valid = '0;
    sif.ent_rdy   = '0;
    sif.ent_fu    = '0;
    sif.fu_rdy    = '0;

    // reset: entry 3 fu0, entry 5 fu2
    add_vec(1, 0, 16'h0028, 32'h0000_0800, 3'b111, 3'b000, 12'h000, 16'h0000, 0);
    add_vec(1, 0, 16'h0028, 32'h0000_0800, 3'b111, 3'b000, 12'h000, 16'h0000, 0);
    add_vec(0, 0, 16'h0028, 32'h0000_0800, 3'b111, 3'b000, 12'h000, 16'h0000, 0);
    add_vec(0, 0, 16'h0028, 32'h0000_0800, 3'b111, 3'b101, 12'h503, 16'h0028, 0);
    add_vec(0, 0, 16'h0000, 32'h0000_0800, 3'b111, 3'b000, 12'h503, 16'h0000, 2);
    // round-robin 1,4,9 then wrap via 15
    add_vec(1, 0, 16'h0000, 32'h0, 3'b001, 3'b000, 12'h503, 16'h0000, 2);
    add_vec(0, 0, 16'h0212, 32'h0, 3'b001, 3'b000, 12'h000, 16'h0000, 0);
    add_vec(0, 0, 16'h0212, 32'h0, 3'b001, 3'b001, 12'h001, 16'h0002, 0);
    add_vec(0, 0, 16'h0210, 32'h0, 3'b001, 3'b001, 12'h004, 16'h0010, 1);
    add_vec(0, 0, 16'h0200, 32'h0, 3'b001, 3'b001, 12'h009, 16'h0200, 2);
    add_vec(0, 0, 16'h0000, 32'h0, 3'b001, 3'b000, 12'h009, 16'h0000, 3);
    add_vec(0, 0, 16'h8004, 32'h0, 3'b001, 3'b000, 12'h009, 16'h0000, 3);
    add_vec(0, 0, 16'h8004, 32'h0, 3'b001, 3'b001, 12'h00F, 16'h8000, 3);
    add_vec(0, 0, 16'h0004, 32'h0, 3'b001, 3'b001, 12'h002, 16'h0004, 4);
    add_vec(0, 0, 16'h0000, 32'h0, 3'b001, 3'b000, 12'h002, 16'h0000, 5);
    // mem backpressure: entries 7 and 10 on fu2
    add_vec(0, 0, 16'h0480, 32'h0020_8000, 3'b000, 3'b000, 12'h002, 16'h0000, 5);
    for (int k = 0; k < 4; k++)
      add_vec(0, 0, 16'h0480, 32'h0020_8000, 3'b000, 3'b100, 12'h702, 16'h0000, 5);
    add_vec(0, 0, 16'h0480, 32'h0020_8000, 3'b100, 3'b100, 12'h702, 16'h0080, 5);
    add_vec(0, 0, 16'h0400, 32'h0020_8000, 3'b100, 3'b100, 12'hA02, 16'h0400, 6);
    add_vec(0, 0, 16'h0000, 32'h0020_8000, 3'b000, 3'b000, 12'hA02, 16'h0000, 7);
    // triple issue
    add_vec(0, 0, 16'h4005, 32'h2000_0010, 3'b111, 3'b000, 12'hA02, 16'h0000, 7);
    add_vec(0, 0, 16'h4005, 32'h2000_0010, 3'b111, 3'b111, 12'hE20, 16'h4005, 7);
    add_vec(0, 0, 16'h0000, 32'h2000_0010, 3'b111, 3'b000, 12'hE20, 16'h0000, 10);
    // flush with held grant, pointer restart
    add_vec(0, 0, 16'h0021, 32'h0, 3'b000, 3'b000, 12'hE20, 16'h0000, 10);
    add_vec(0, 0, 16'h0021, 32'h0, 3'b000, 3'b001, 12'hE25, 16'h0000, 10);
    add_vec(0, 1, 16'h0021, 32'h0, 3'b001, 3'b001, 12'hE25, 16'h0000, 10);
    add_vec(0, 0, 16'h0021, 32'h0, 3'b000, 3'b000, 12'hE25, 16'h0000, 10);
    add_vec(0, 0, 16'h0021, 32'h0, 3'b001, 3'b001, 12'hE20, 16'h0001, 10);
    add_vec(0, 0, 16'h0020, 32'h0, 3'b001, 3'b001, 12'hE25, 16'h0020, 11);
    add_vec(0, 0, 16'h0000, 32'h0, 3'b000, 3'b000, 12'hE25, 16'h0000, 12);
    // reset + flush mid-handshake: reset wins, nothing counted or cleared
    add_vec(0, 0, 16'h0008, 32'h0, 3'b000, 3'b000, 12'hE25, 16'h0000, 12);
    add_vec(1, 1, 16'h0008, 32'h0, 3'b001, 3'b001, 12'hE23, 16'h0000, 12);
    add_vec(0, 0, 16'h0000, 32'h0, 3'b000, 3'b000, 12'h000, 16'h0000, 0);
    // illegal fu id 3 on entry 6
    for (int k = 0; k < 10; k++)
      add_vec(0, 0, 16'h0040, 32'h0000_3000, 3'b111, 3'b000, 12'h000, 16'h0000, 0);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset         = tbl[i].rst;
      flush         = tbl[i].fl;
      sif.ent_valid = tbl[i].val;
      sif.ent_rdy   = tbl[i].val;
      sif.ent_fu    = tbl[i].fu;
      sif.fu_rdy    = tbl[i].frdy;
      #1;
      chk($sformatf("tbl[%0d] grant_valid", i), 32'(sif.grant_valid), 32'(tbl[i].e_gv));
      chk($sformatf("tbl[%0d] grant_idx", i),   32'(sif.grant_idx),   32'(tbl[i].e_gidx));
      chk($sformatf("tbl[%0d] clear_vec", i),   32'(sif.clear_vec),   32'(tbl[i].e_clr));
      chk($sformatf("tbl[%0d] issue_cnt", i),   sif.issue_cnt,        tbl[i].e_cnt);
    end

    // randomized phase; DUT is in its reset state after the table
    for (int j = 0; j < 3; j++) begin
      m_gv[j] = 0; m_gidx[j] = 0; m_ptr[j] = 0;
    end
    m_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      rs_val[i] = 1'b0; rs_fu[i] = 0; rs_rdy[i] = 1'b0;
    end

    for (int it = 0; it < 500; it++) begin
      logic        r, f;
      logic [2:0]  fr;
      logic [15:0] e_clr;
      logic [11:0] e_gidx;
      logic [2:0]  e_gv;
      bit          acc[3];
      bit          held[16];
      int          n_acc;

      @(negedge clk);
      r  = (it == 0) || ($urandom_range(0, 49) == 0);
      f  = ($urandom_range(0, 19) == 0);
      fr = 3'($urandom_range(0, 7));
      for (int i = 0; i < 16; i++) begin
        if (!rs_val[i] && $urandom_range(0, 3) == 0) begin
          rs_val[i] = 1'b1;
          rs_fu[i]  = int'($urandom_range(0, 3));
        end
        rs_rdy[i] = ($urandom_range(0, 3) != 0);
      end
      reset = r;
      flush = f;
      for (int i = 0; i < 16; i++) begin
        sif.ent_valid[i]       = rs_val[i];
        sif.ent_rdy[i]         = rs_rdy[i];
        sif.ent_fu[2*i +: 2]   = 2'(rs_fu[i]);
      end
      sif.fu_rdy = fr;
      #1;

      e_clr = '0; e_gv = '0; e_gidx = '0; n_acc = 0;
      for (int i = 0; i < 16; i++) held[i] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        acc[j] = (m_gv[j] != 0) && fr[j];
        if (m_gv[j] != 0) held[m_gidx[j]] = 1'b1;
        if (acc[j]) begin
          n_acc++;
          if (!r && !f) e_clr[m_gidx[j]] = 1'b1;
        end
        e_gv[j] = (m_gv[j] != 0);
        e_gidx[4*j +: 4] = 4'(m_gidx[j]);
      end
      chk($sformatf("rnd[%0d] grant_valid", it), 32'(sif.grant_valid), 32'(e_gv));
      chk($sformatf("rnd[%0d] grant_idx", it),   32'(sif.grant_idx),   32'(e_gidx));
      chk($sformatf("rnd[%0d] clear_vec", it),   32'(sif.clear_vec),   32'(e_clr));
      chk($sformatf("rnd[%0d] issue_cnt", it),   sif.issue_cnt,        m_cnt);

      // advance model to the state after the coming edge
      if (r) begin
        for (int j = 0; j < 3; j++) begin
          m_gv[j] = 0; m_gidx[j] = 0; m_ptr[j] = 0;
        end
        m_cnt = '0;
      end else if (f) begin
        for (int j = 0; j < 3; j++) begin
          m_gv[j] = 0; m_ptr[j] = 0;
        end
      end else begin
        m_cnt = m_cnt + 32'(n_acc);
        for (int j = 0; j < 3; j++) begin
          if (m_gv[j] == 0 || acc[j]) begin
            int k_sel;
            k_sel = -1;
            for (int off = 0; off < 16; off++) begin
              int k;
              k = (m_ptr[j] + off) % 16;
              if (k_sel < 0 && rs_val[k] && rs_rdy[k] && !held[k] && rs_fu[k] == j)
                k_sel = k;
            end
            if (k_sel >= 0) begin
              m_gv[j]   = 1;
              m_gidx[j] = k_sel;
              m_ptr[j]  = (k_sel + 1) % 16;
            end else begin
              m_gv[j] = 0;
            end
          end
        end
        for (int i = 0; i < 16; i++)
          if (e_clr[i]) rs_val[i] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
